// File: rtl/ctpuf_pkg.sv
// rtl/ctpuf_pkg.sv - shared state encoding and default constants for the CT-PUF evaluation controller
package ctpuf_pkg;

    localparam int CTPUF_CHAL_W = 8;
    localparam int CTPUF_RESP_W = 8;
    localparam int CTPUF_SETTLE = 16;
    localparam int CTPUF_NSAMP  = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_NEXT   = 3'd3,
        ST_DONE   = 3'd4
    } ctpuf_state_e;

endpackage

// File: rtl/ctpuf_sync2.sv
// rtl/ctpuf_sync2.sv - two-flop synchroniser bringing a PUF output into the clk domain
module ctpuf_sync2 (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ctpuf_eval_ctrl.sv
// rtl/ctpuf_eval_ctrl.sv - CT-PUF challenge/response sequencer with per-bit settle and majority vote
module ctpuf_eval_ctrl
    import ctpuf_pkg::*;
#(
    parameter int CHAL_W = CTPUF_CHAL_W,
    parameter int RESP_W = CTPUF_RESP_W,
    parameter int SETTLE = CTPUF_SETTLE,
    parameter int NSAMP  = CTPUF_NSAMP
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [CHAL_W-1:0] chal_in_i,
    input  logic              puf_out_i,
    output logic              puf_en_o,
    output logic [CHAL_W-1:0] puf_chal_o,
    output logic              busy_o,
    output logic [RESP_W-1:0] resp_o,
    output logic              resp_valid_o
);

    localparam int SET_W  = $clog2(SETTLE + 1);
    localparam int SMP_W  = $clog2(NSAMP + 1);
    localparam int IDX_W  = $clog2(RESP_W + 1);

    ctpuf_state_e      state_q, state_d;
    logic [CHAL_W-1:0] chal_q, chal_d;
    logic [CHAL_W-1:0] puf_chal_q, puf_chal_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SET_W-1:0]  set_cnt_q, set_cnt_d;
    logic [SMP_W-1:0]  smp_cnt_q, smp_cnt_d;
    logic [SMP_W-1:0]  ones_q, ones_d;
    logic [RESP_W-1:0] shadow_q, shadow_d;
    logic [RESP_W-1:0] resp_q, resp_d;

    logic              puf_sync;
    logic              settle_last;
    logic              sample_last;
    logic              bit_last;
    logic              vote;
    logic [RESP_W-1:0] bit_mask;
    logic [RESP_W-1:0] shadow_upd;

    ctpuf_sync2 u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (puf_out_i),
        .q_o     (puf_sync)
    );

    assign settle_last = (set_cnt_q == SET_W'(SETTLE - 1));
    assign sample_last = (smp_cnt_q == SMP_W'(NSAMP - 1));
    assign bit_last    = (idx_q == IDX_W'(RESP_W - 1));
    assign vote        = (ones_q > SMP_W'(NSAMP / 2));
    assign bit_mask    = RESP_W'(1) << idx_q;
    assign shadow_upd  = vote ? (shadow_q | bit_mask) : (shadow_q & ~bit_mask);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_i)     state_d = ST_SETTLE;
            ST_SETTLE: if (settle_last) state_d = ST_SAMPLE;
            ST_SAMPLE: if (sample_last) state_d = ST_NEXT;
            ST_NEXT:   state_d = bit_last ? ST_DONE : ST_SETTLE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        puf_en_o     = 1'b0;
        busy_o       = 1'b1;
        resp_valid_o = 1'b0;
        unique case (state_q)
            ST_IDLE:   busy_o       = 1'b0;
            ST_SETTLE: puf_en_o     = 1'b1;
            ST_SAMPLE: puf_en_o     = 1'b1;
            ST_NEXT:   puf_en_o     = 1'b0;
            ST_DONE:   resp_valid_o = 1'b1;
            default:   busy_o       = 1'b0;
        endcase
    end

    // resp is loaded on the final NEXT edge so it is already stable while DONE pulses resp_valid
    always_comb begin
        chal_d     = chal_q;
        puf_chal_d = puf_chal_q;
        idx_d      = idx_q;
        set_cnt_d  = set_cnt_q;
        smp_cnt_d  = smp_cnt_q;
        ones_d     = ones_q;
        shadow_d   = shadow_q;
        resp_d     = resp_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    chal_d     = chal_in_i;
                    puf_chal_d = chal_in_i;
                    idx_d      = '0;
                    set_cnt_d  = '0;
                    smp_cnt_d  = '0;
                    ones_d     = '0;
                    shadow_d   = '0;
                end
            end
            ST_SETTLE: begin
                set_cnt_d = settle_last ? '0 : set_cnt_q + SET_W'(1);
            end
            ST_SAMPLE: begin
                smp_cnt_d = sample_last ? '0 : smp_cnt_q + SMP_W'(1);
                ones_d    = ones_q + SMP_W'(puf_sync);
            end
            ST_NEXT: begin
                shadow_d = shadow_upd;
                ones_d   = '0;
                if (bit_last) begin
                    resp_d = shadow_upd;
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    puf_chal_d = chal_q ^ CHAL_W'(idx_q + IDX_W'(1));
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            chal_q     <= '0;
            puf_chal_q <= '0;
            idx_q      <= '0;
            set_cnt_q  <= '0;
            smp_cnt_q  <= '0;
            ones_q     <= '0;
            shadow_q   <= '0;
            resp_q     <= '0;
        end else begin
            chal_q     <= chal_d;
            puf_chal_q <= puf_chal_d;
            idx_q      <= idx_d;
            set_cnt_q  <= set_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            ones_q     <= ones_d;
            shadow_q   <= shadow_d;
            resp_q     <= resp_d;
        end
    end

    assign puf_chal_o = puf_chal_q;
    assign resp_o     = resp_q;

endmodule

// File: tb/tb_ctpuf_eval_ctrl.sv
// tb/tb_ctpuf_eval_ctrl.sv - directed self-checking bench for ctpuf_eval_ctrl
module tb_ctpuf_eval_ctrl;

    localparam int HMAX = 400;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [7:0] chal_in_i;
    logic       puf_out_i;
    logic       puf_en_o;
    logic [7:0] puf_chal_o;
    logic       busy_o;
    logic [7:0] resp_o;
    logic       resp_valid_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic       en_h   [0:HMAX];
    logic       busy_h [0:HMAX];
    logic       rv_h   [0:HMAX];
    logic [7:0] chal_h [0:HMAX];
    logic [7:0] resp_h [0:HMAX];
    int         hlen;

    always #5 clk = ~clk;

    ctpuf_eval_ctrl dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .chal_in_i    (chal_in_i),
        .puf_out_i    (puf_out_i),
        .puf_en_o     (puf_en_o),
        .puf_chal_o   (puf_chal_o),
        .busy_o       (busy_o),
        .resp_o       (resp_o),
        .resp_valid_o (resp_valid_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] parity_model(input logic [7:0] c);
        logic [7:0] r;
        logic [7:0] d;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            d    = c ^ 8'(i);
            r[i] = ^d;
        end
        return r;
    endfunction

    function automatic int first_rv();
        for (int n = 1; n <= hlen; n++) begin
            if (rv_h[n] === 1'b1) return n;
        end
        return -1;
    endfunction

    function automatic int count_rv();
        int c;
        c = 0;
        for (int n = 1; n <= hlen; n++) begin
            if (rv_h[n] === 1'b1) c++;
        end
        return c;
    endfunction

    // puf_en must be high for all 192 busy cycles except the NEXT cycles at every 24th
    function automatic int en_pattern_errors();
        int e;
        e = 0;
        for (int n = 1; n <= 192; n++) begin
            if (en_h[n] !== ((n % 24) != 0)) e++;
        end
        return e;
    endfunction

    // Cycle n is the n-th cycle after the start edge; mode 0/1 tied, 2 = n ones in bit 0, 3 = parity PUF
    task automatic run_eval(input logic [7:0] chal, input int mode, input int nones,
                            input int s1, input int s2, input int s3,
                            input int rst_at, input int ncyc);
        @(negedge clk);
        chal_in_i = chal;
        start_i   = 1'b1;
        puf_out_i = (mode == 1);
        @(posedge clk);
        hlen = ncyc;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            en_h[n]   = puf_en_o;
            busy_h[n] = busy_o;
            rv_h[n]   = resp_valid_o;
            chal_h[n] = puf_chal_o;
            resp_h[n] = resp_o;
            start_i   = (n == s1) || (n == s2) || (n == s3);
            reset_i   = !(rst_at != 0 && n >= rst_at && n < rst_at + 3);
            case (mode)
                0:       puf_out_i = 1'b0;
                1:       puf_out_i = 1'b1;
                2:       puf_out_i = (n >= 15) && (n < 15 + nones);
                default: puf_out_i = ^puf_chal_o;
            endcase
        end
        start_i = 1'b0;
        reset_i = 1'b1;
    endtask

    logic [7:0] seq_exp [0:7];

    initial begin
        reset_i   = 1'b0;
        start_i   = 1'b0;
        chal_in_i = 8'h00;
        puf_out_i = 1'b0;
        seq_exp[0] = 8'hA5; seq_exp[1] = 8'hA4; seq_exp[2] = 8'hA7; seq_exp[3] = 8'hA6;
        seq_exp[4] = 8'hA1; seq_exp[5] = 8'hA0; seq_exp[6] = 8'hA3; seq_exp[7] = 8'hA2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_en", 32'(puf_en_o), 32'd0);
        chk("rst_chal", 32'(puf_chal_o), 32'd0);
        chk("rst_resp", 32'(resp_o), 32'd0);
        chk("rst_rv", 32'(resp_valid_o), 32'd0);
        reset_i = 1'b1;

        // tied 1: latency, response, derived challenge sequence
        run_eval(8'hA5, 1, 0, 0, 0, 0, 0, 200);
        chk("t2_latency", 32'(first_rv()), 32'd193);
        chk("t2_rv_count", 32'(count_rv()), 32'd1);
        chk("t2_resp", 32'(resp_h[193]), 32'hFF);
        chk("t2_resp_hold", 32'(resp_h[200]), 32'hFF);
        chk("t2_busy_done", 32'(busy_h[193]), 32'd1);
        chk("t2_busy_after", 32'(busy_h[194]), 32'd0);
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("t2_chal%0d", b), 32'(chal_h[1 + 24 * b]), 32'(seq_exp[b]));
        end
        chk("t2_en_pattern", 32'(en_pattern_errors()), 32'd0);

        // reset held low for 3 cycles mid-evaluation
        run_eval(8'hA5, 1, 0, 0, 0, 0, 50, 260);
        chk("t1_busy", 32'(busy_h[53]), 32'd0);
        chk("t1_en", 32'(puf_en_o), 32'd0);
        chk("t1_chal", 32'(chal_h[53]), 32'd0);
        chk("t1_resp", 32'(resp_h[53]), 32'd0);
        chk("t1_no_rv", 32'(count_rv()), 32'd0);
        chk("t1_idle_end", 32'(busy_h[260]), 32'd0);

        // tied 0, run normally after the abort
        run_eval(8'h5A, 0, 0, 0, 0, 0, 0, 200);
        chk("t3_latency", 32'(first_rv()), 32'd193);
        chk("t3_resp", 32'(resp_h[193]), 32'h00);
        chk("t3_en_pattern", 32'(en_pattern_errors()), 32'd0);

        // majority threshold on bit 0 (after a 0xFF word so the result is not stale)
        run_eval(8'hA5, 1, 0, 0, 0, 0, 0, 200);
        chk("t4_pre", 32'(resp_h[193]), 32'hFF);
        run_eval(8'h00, 2, 4, 0, 0, 0, 0, 200);
        chk("t4_4of7", 32'(resp_h[193]), 32'h01);
        run_eval(8'h00, 2, 3, 0, 0, 0, 0, 200);
        chk("t4_3of7", 32'(resp_h[193]), 32'h00);

        // behavioural parity PUF
        run_eval(8'h3C, 3, 0, 0, 0, 0, 0, 200);
        chk("t6_latency", 32'(first_rv()), 32'd193);
        chk("t6_resp", 32'(resp_h[193]), 32'(parity_model(8'h3C)));

        // start while busy (cycle 11) and in DONE (cycle 193) ignored; cycle 194 accepted
        run_eval(8'h01, 3, 0, 11, 193, 194, 0, 392);
        chk("t5_first_rv", 32'(first_rv()), 32'd193);
        chk("t5_resp", 32'(resp_h[193]), 32'(parity_model(8'h01)));
        chk("t5_idle_gap", 32'(busy_h[194]), 32'd0);
        chk("t5_restart", 32'(busy_h[195]), 32'd1);
        chk("t5_second_rv", 32'(rv_h[387]), 32'd1);
        chk("t5_rv_count", 32'(count_rv()), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
